oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, the address of the DMA source register.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, the first destination address.
REQ-003 SHALL have parameter XFER_LEN, default 160, the number of bytes per transfer.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-006 SHALL have port cpu_r_addr, input, 16 bits, core read address.
REQ-007 SHALL have port cpu_w_addr, input, 16 bits, core write address.
REQ-008 SHALL have port cpu_w_data, input, 8 bits, core write data.
REQ-009 SHALL have port cpu_w_wen, input, 1 bit, core write enable.
REQ-010 SHALL have port cpu_r_data, output, 8 bits, read data returned to the core.
REQ-011 SHALL have port mem_r_addr, output, 16 bits, memory read address.
REQ-012 SHALL have port mem_w_addr, output, 16 bits, memory write address.
REQ-013 SHALL have port mem_w_data, output, 8 bits, memory write data.
REQ-014 SHALL have port mem_w_wen, output, 1 bit, memory write enable.
REQ-015 SHALL have port mem_r_data, input, 8 bits; memory read data, valid one clk after mem_r_addr is presented.
REQ-016 SHALL have port dma_active, output, 1 bit, high while the block owns the memory bus.

Function
REQ-017 SHALL hold an 8-bit source register src_hi; a clocked cpu_w_wen with cpu_w_addr==DMA_REG_ADDR loads cpu_w_data into it and starts a transfer.
REQ-018 SHALL never forward a DMA_REG_ADDR write to memory; mem_w_wen stays 0 in that cycle.
REQ-019 SHALL form the source page as src_hi when src_hi<=8'hDF, and src_hi-8'h20 otherwise (echo mapping).
REQ-020 SHALL implement the states IDLE, XFER and DRAIN.
REQ-021 SHALL move IDLE->XFER on a start write.
REQ-022 SHALL, in XFER, keep an 8-bit index i starting at 0 and drive mem_r_addr={page,i}.
REQ-023 SHALL, in XFER for i>=1, drive mem_w_addr=OAM_BASE+i-1, mem_w_data=mem_r_data and mem_w_wen=1.
REQ-024 SHALL increment i every clk in XFER and move XFER->DRAIN after the cycle with i==XFER_LEN-1.
REQ-025 SHALL, in DRAIN, write the final byte to OAM_BASE+XFER_LEN-1 with no read, then return to IDLE.
REQ-026 SHALL hold dma_active high exactly in XFER and DRAIN: XFER_LEN+1 cycles for an uninterrupted transfer, first cycle being the one after the start write.
REQ-027 SHALL, in IDLE, pass cpu_r_addr, cpu_w_addr, cpu_w_data and cpu_w_wen straight through to the mem_* ports.
REQ-028 SHALL, while dma_active, drop all CPU writes other than DMA_REG_ADDR.
REQ-029 SHALL return cpu_r_data==8'hFF for any CPU read issued while dma_active, with the same one-cycle alignment as memory data.
REQ-030 SHALL return src_hi on cpu_r_data in the cycle after a read of DMA_REG_ADDR, regardless of state.
REQ-031 SHALL otherwise return mem_r_data on cpu_r_data.
REQ-032 SHALL, on a start write during XFER or DRAIN, discard the in-flight byte (no write for it), reload src_hi, set i=0 and enter XFER on the next clk.
REQ-033 SHALL give a simultaneous start write and the last DRAIN cycle this priority: the DRAIN write completes, then XFER restarts.

Reset
REQ-034 SHALL, while rst_n==0, immediately force state=IDLE, i=0, src_hi=8'hFF, dma_active=0, mem_w_wen=0 and cpu_r_data=8'hFF.
REQ-035 SHALL, on reset mid-transfer, abort immediately with no further OAM writes and no resume after reset release.

Verification
REQ-036 Start: write 8'hC1 to FF46 -> dma_active high 161 cycles; bytes C100..C19F land in FE00..FE9F in order, one per cycle.
REQ-037 CPU lockout: during DMA read 0xC000 -> cpu_r_data 8'hFF; write 8'h55 to 0xC000 -> memory unchanged.
REQ-038 Echo: write 8'hE3 to FF46 -> source page C3.
REQ-039 Restart: write 8'hC2 at i==50 -> no write for the in-flight byte; FE00..FE9F finally hold C200..C29F; dma_active stays high throughout.
REQ-040 Reset: assert rst_n=0 at i==80 -> dma_active=0 and mem_w_wen=0 at once; FF46 read after release returns 8'hFF.
REQ-041 Readback and idle pass-through: read FF46 after writing 8'h12 -> 8'h12; in IDLE, write 8'hAB to 0xC005 then read it back -> 8'hAB.

Source files
------------

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies XFER_LEN bytes from page {src_hi,00} into OAM,
// one byte per clock, while locking the core off the shared memory bus.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_r_addr,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [7:0]  cpu_r_data,
  output logic [15:0] mem_r_addr,
  output logic [15:0] mem_w_addr,
  output logic [7:0]  mem_w_data,
  output logic        mem_w_wen,
  input  logic [7:0]  mem_r_data,
  output logic        dma_active
);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  localparam logic [7:0]  LAST_IDX  = 8'(XFER_LEN - 1);
  localparam logic [15:0] LAST_ADDR = OAM_BASE + 16'(XFER_LEN - 1);

  state_t     state_q;
  logic [7:0] i_q;
  logic [7:0] src_hi_q;
  logic       dma_active_q;
  logic       rd_reg_q;
  logic       rd_blk_q;

  logic       start;
  logic [7:0] page;

  assign start = cpu_w_wen && (cpu_w_addr == DMA_REG_ADDR);
  // Pages E0..FF are echoes of C0..DF.
  assign page  = (src_hi_q > 8'hDF) ? (src_hi_q - 8'h20) : src_hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      i_q          <= 8'h00;
      src_hi_q     <= 8'hFF;
      dma_active_q <= 1'b0;
      rd_reg_q     <= 1'b0;
      rd_blk_q     <= 1'b1;
    end else begin
      rd_reg_q <= (cpu_r_addr == DMA_REG_ADDR);
      rd_blk_q <= dma_active_q;
      if (start) begin
        // A restart drops the byte read this cycle; any write already on the bus completes.
        src_hi_q     <= cpu_w_data;
        state_q      <= XFER;
        i_q          <= 8'h00;
        dma_active_q <= 1'b1;
      end else begin
        case (state_q)
          XFER: begin
            i_q <= i_q + 8'h01;
            if (i_q == LAST_IDX) state_q <= DRAIN;
          end
          DRAIN: begin
            state_q      <= IDLE;
            i_q          <= 8'h00;
            dma_active_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_r_addr = cpu_r_addr;
    mem_w_addr = cpu_w_addr;
    mem_w_data = cpu_w_data;
    mem_w_wen  = rst_n && cpu_w_wen && !start;
    case (state_q)
      XFER: begin
        mem_r_addr = {page, i_q};
        mem_w_addr = OAM_BASE + {8'h00, i_q} - 16'd1;
        mem_w_data = mem_r_data;
        mem_w_wen  = (i_q != 8'h00);
      end
      DRAIN: begin
        mem_r_addr = {page, i_q};
        mem_w_addr = LAST_ADDR;
        mem_w_data = mem_r_data;
        mem_w_wen  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (rd_reg_q)      cpu_r_data = src_hi_q;
    else if (rd_blk_q) cpu_r_data = 8'hFF;
    else               cpu_r_data = mem_r_data;
  end

  assign dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma against a 64 KiB memory model with one-cycle read latency.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_r_addr, cpu_w_addr;
  logic [7:0]  cpu_w_data;
  logic        cpu_w_wen;
  logic [7:0]  cpu_r_data;
  logic [15:0] mem_r_addr, mem_w_addr;
  logic [7:0]  mem_w_data;
  logic        mem_w_wen;
  logic [7:0]  mem_r_data;
  logic        dma_active;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];
  bit         filled = 1'b0;

  always #5 clk = ~clk;

  oam_dma dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_r_addr (cpu_r_addr),
    .cpu_w_addr (cpu_w_addr),
    .cpu_w_data (cpu_w_data),
    .cpu_w_wen  (cpu_w_wen),
    .cpu_r_data (cpu_r_data),
    .mem_r_addr (mem_r_addr),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_w_wen  (mem_w_wen),
    .mem_r_data (mem_r_data),
    .dma_active (dma_active)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clk) begin
    if (!filled) begin
      for (int a = 0; a < 65536; a++) mem[a] <= pat(16'(a));
      filled <= 1'b1;
    end
    mem_r_data <= mem[mem_r_addr];
    if (mem_w_wen) mem[mem_w_addr] <= mem_w_data;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_w_wen  = 1'b0;
    cpu_w_addr = 16'h0000;
    cpu_w_data = 8'h00;
    cpu_r_addr = 16'h0000;
  endtask

  task automatic start_dma(input logic [7:0] v);
    tick();
    idle_inputs();
    cpu_w_wen  = 1'b1;
    cpu_w_addr = 16'hFF46;
    cpu_w_data = v;
    @(negedge clk);
    chk("reg_wr_not_fwd", {15'd0, mem_w_wen}, 16'd0);
  endtask

  task automatic xfer_checks(input int k, input logic [7:0] pg);
    chk("active", {15'd0, dma_active}, 16'd1);
    if (k < 160) chk("raddr", mem_r_addr, {pg, 8'(k)});
    if (k >= 1) begin
      chk("wen", {15'd0, mem_w_wen}, 16'd1);
      chk("waddr", mem_w_addr, 16'hFE00 + 16'(k - 1));
      chk("wdata", {8'd0, mem_w_data}, {8'd0, pat({pg, 8'(k - 1)})});
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dma_active && n < 400) begin
      tick();
      idle_inputs();
      @(negedge clk);
      n++;
    end
    chk("wait_idle", {15'd0, dma_active}, 16'd0);
  endtask

  task automatic oam_check(input string tag, input logic [7:0] pg);
    int errs = 0;
    for (int j = 0; j < 160; j++)
      if (mem[16'hFE00 + 16'(j)] !== pat({pg, 8'(j)})) errs++;
    chk(tag, 16'(errs), 16'd0);
  endtask

  initial begin
    // Reset with a CPU write pending: it must not reach memory.
    rst_n      = 1'b0;
    cpu_r_addr = 16'h0000;
    cpu_w_wen  = 1'b1;
    cpu_w_addr = 16'hC010;
    cpu_w_data = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_active", {15'd0, dma_active}, 16'd0);
    chk("rst_wen", {15'd0, mem_w_wen}, 16'd0);
    chk("rst_rdata", {8'd0, cpu_r_data}, 16'h00FF);
    tick();
    rst_n = 1'b1;
    idle_inputs();

    // Full transfer from C1 with CPU lockout at k=10.
    start_dma(8'hC1);
    chk("idle_before", {15'd0, dma_active}, 16'd0);
    for (int k = 0; k <= 160; k++) begin
      tick();
      idle_inputs();
      if (k == 10) begin
        cpu_r_addr = 16'hC000;
        cpu_w_wen  = 1'b1;
        cpu_w_addr = 16'hC000;
        cpu_w_data = 8'h55;
      end
      @(negedge clk);
      xfer_checks(k, 8'hC1);
      if (k == 11) chk("lock_rd", {8'd0, cpu_r_data}, 16'h00FF);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    chk("done_c1", {15'd0, dma_active}, 16'd0);
    oam_check("oam_c1", 8'hC1);
    chk("lock_wr", {8'd0, mem[16'hC000]}, 16'h00C0);

    // Echo page.
    start_dma(8'hE3);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("echo_p0", mem_r_addr, 16'hC300);
    tick();
    @(negedge clk);
    chk("echo_p1", mem_r_addr, 16'hC301);
    wait_idle();
    oam_check("oam_echo", 8'hC3);

    // Restart at i==50.
    start_dma(8'hC1);
    for (int k = 0; k <= 50; k++) begin
      tick();
      idle_inputs();
      if (k == 50) begin
        cpu_w_wen  = 1'b1;
        cpu_w_addr = 16'hFF46;
        cpu_w_data = 8'hC2;
      end
      @(negedge clk);
      chk("pre_restart_active", {15'd0, dma_active}, 16'd1);
    end
    for (int k = 0; k <= 160; k++) begin
      tick();
      idle_inputs();
      @(negedge clk);
      if (k == 0) chk("restart_drop", {15'd0, mem_w_wen}, 16'd0);
      xfer_checks(k, 8'hC2);
    end
    tick();
    @(negedge clk);
    chk("done_c2", {15'd0, dma_active}, 16'd0);
    oam_check("oam_c2", 8'hC2);

    // Reset at i==80.
    start_dma(8'hC1);
    for (int k = 0; k < 80; k++) begin
      tick();
      idle_inputs();
      @(negedge clk);
      chk("pre_rst_active", {15'd0, dma_active}, 16'd1);
    end
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_active", {15'd0, dma_active}, 16'd0);
    chk("midrst_wen", {15'd0, mem_w_wen}, 16'd0);
    repeat (2) tick();
    rst_n      = 1'b1;
    cpu_r_addr = 16'hFF46;
    @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      tick();
      @(negedge clk);
      if (n == 0) chk("rd_ff46_after_rst", {8'd0, cpu_r_data}, 16'h00FF);
      if (mem_w_wen !== 1'b0 || dma_active !== 1'b0) chk("no_resume", {14'd0, dma_active, mem_w_wen}, 16'd0);
    end
    chk("rst_last_written", {8'd0, mem[16'hFE4E]}, {8'd0, pat(16'hC14E)});
    chk("rst_not_written", {8'd0, mem[16'hFE4F]}, {8'd0, pat(16'hC24F)});

    // Readback of the source register, then idle pass-through.
    start_dma(8'h12);
    tick();
    idle_inputs();
    cpu_r_addr = 16'hFF46;
    @(negedge clk);
    tick();
    cpu_r_addr = 16'h0000;
    @(negedge clk);
    chk("rd_src_hi", {8'd0, cpu_r_data}, 16'h0012);
    wait_idle();
    tick();
    idle_inputs();
    cpu_w_wen  = 1'b1;
    cpu_w_addr = 16'hC005;
    cpu_w_data = 8'hAB;
    @(negedge clk);
    chk("pt_wen", {15'd0, mem_w_wen}, 16'd1);
    chk("pt_waddr", mem_w_addr, 16'hC005);
    chk("pt_wdata", {8'd0, mem_w_data}, 16'h00AB);
    tick();
    idle_inputs();
    cpu_r_addr = 16'hC005;
    @(negedge clk);
    chk("pt_raddr", mem_r_addr, 16'hC005);
    tick();
    cpu_r_addr = 16'h0000;
    @(negedge clk);
    chk("pt_rdata", {8'd0, cpu_r_data}, 16'h00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
